// File: rtl/zculling_stage.sv
// zculling_stage: depth-tests fragments from four ap_vld/ap_ack lanes against
// an on-chip Z-buffer and forwards visible pixels on one output stream.
// Optional statistics counters are enabled with `define ZCULL_STATS_EN.
module zculling_stage #(
  parameter int unsigned ZB_ADDR_BITS = 16,
  parameter logic [7:0]  Z_INIT       = 8'hFF,
  parameter logic [31:0] EOF_WORD     = 32'hFFFF_FFFF
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic [31:0] Input_1_V_V,
  input  logic        Input_1_V_V_ap_vld,
  output logic        Input_1_V_V_ap_ack,
  input  logic [31:0] Input_2_V_V,
  input  logic        Input_2_V_V_ap_vld,
  output logic        Input_2_V_V_ap_ack,
  input  logic [31:0] Input_3_V_V,
  input  logic        Input_3_V_V_ap_vld,
  output logic        Input_3_V_V_ap_ack,
  input  logic [31:0] Input_4_V_V,
  input  logic        Input_4_V_V_ap_vld,
  output logic        Input_4_V_V_ap_ack,
  output logic [31:0] Output_1_V_V,
  output logic        Output_1_V_V_ap_vld,
  input  logic        Output_1_V_V_ap_ack,
  output logic        busy
`ifdef ZCULL_STATS_EN
  ,
  output logic [31:0] stat_frag_in,
  output logic [31:0] stat_frag_pass,
  output logic [15:0] stat_frames
`endif
);

  typedef enum logic [2:0] {
    S_CLEAR, S_ARB, S_HDR, S_FRAG_RD, S_FRAG_CMP, S_OUT_WAIT, S_EOF_OUT
  } state_t;

  state_t                  r_state;
  logic [1:0]              r_rr_ptr;
  logic [1:0]              r_lane;
  logic [ZB_ADDR_BITS-1:0] r_clr_addr;
  logic                    r_clr_to_eof;
  logic [15:0]             r_remaining;
  logic [7:0]              r_fx, r_fy, r_fz, r_fcol;
  logic [7:0]              r_zrd;
  logic [7:0]              r_zbuf [0:(1 << ZB_ADDR_BITS)-1];

  logic [31:0]             w_in_data [4];
  logic [3:0]              w_in_vld;
  logic [31:0]             w_cur_word;
  logic                    w_cur_vld;
  logic                    w_ack_en;
  logic                    w_arb_found;
  logic [1:0]              w_arb_lane;
  logic [1:0]              w_arb_idx;
  logic [15:0]             w_in_xy;
  logic [15:0]             w_frag_xy;
  logic                    w_pass;
  logic                    w_ram_we;
  logic                    w_ram_re;
  logic [ZB_ADDR_BITS-1:0] w_ram_addr;
  logic [7:0]              w_ram_wd;

  assign w_in_data[0] = Input_1_V_V;
  assign w_in_data[1] = Input_2_V_V;
  assign w_in_data[2] = Input_3_V_V;
  assign w_in_data[3] = Input_4_V_V;
  assign w_in_vld     = {Input_4_V_V_ap_vld, Input_3_V_V_ap_vld,
                         Input_2_V_V_ap_vld, Input_1_V_V_ap_vld};

  assign w_cur_word = w_in_data[r_lane];
  assign w_cur_vld  = w_in_vld[r_lane];
  assign w_ack_en   = (r_state == S_HDR) || (r_state == S_FRAG_RD);

  // Ack is gated by the lane's own vld so it only pulses in the transfer cycle
  assign Input_1_V_V_ap_ack = w_ack_en && (r_lane == 2'd0) && Input_1_V_V_ap_vld;
  assign Input_2_V_V_ap_ack = w_ack_en && (r_lane == 2'd1) && Input_2_V_V_ap_vld;
  assign Input_3_V_V_ap_ack = w_ack_en && (r_lane == 2'd2) && Input_3_V_V_ap_vld;
  assign Input_4_V_V_ap_ack = w_ack_en && (r_lane == 2'd3) && Input_4_V_V_ap_vld;

  assign busy = (r_state != S_ARB);

  assign w_in_xy   = w_cur_word[31:16];
  assign w_frag_xy = {r_fx, r_fy};
  assign w_pass    = (r_fz < r_zrd);

  // Round-robin pick: first valid lane after rr_ptr, wrapping to rr_ptr itself last
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_lane  = r_rr_ptr;
    w_arb_idx   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      w_arb_idx = r_rr_ptr + i[1:0];
      if (!w_arb_found && w_in_vld[w_arb_idx]) begin
        w_arb_found = 1'b1;
        w_arb_lane  = w_arb_idx;
      end
    end
  end

  // Single-port Z-buffer address/write mux: clear sweep, depth update, or lookup
  always_comb begin
    w_ram_we   = 1'b0;
    w_ram_re   = 1'b0;
    w_ram_addr = w_in_xy[ZB_ADDR_BITS-1:0];
    w_ram_wd   = Z_INIT;
    case (r_state)
      S_CLEAR: begin
        w_ram_we   = 1'b1;
        w_ram_addr = r_clr_addr;
      end
      S_FRAG_CMP: begin
        w_ram_we   = w_pass;
        w_ram_addr = w_frag_xy[ZB_ADDR_BITS-1:0];
        w_ram_wd   = r_fz;
      end
      S_FRAG_RD: w_ram_re = w_cur_vld;
      default: ;
    endcase
  end

  // Z-buffer storage: synchronous write or 1-cycle-latency read, no reset
  always_ff @(posedge ap_clk) begin
    if (w_ram_we)
      r_zbuf[w_ram_addr] <= w_ram_wd;
    else if (w_ram_re)
      r_zrd <= r_zbuf[w_ram_addr];
  end

  // Main control FSM with registered output stream
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state             <= S_CLEAR;
      r_rr_ptr            <= 2'd0;
      r_lane              <= 2'd0;
      r_clr_addr          <= '0;
      r_clr_to_eof        <= 1'b0;
      r_remaining         <= '0;
      r_fx                <= '0;
      r_fy                <= '0;
      r_fz                <= '0;
      r_fcol              <= '0;
      Output_1_V_V        <= '0;
      Output_1_V_V_ap_vld <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == '1) begin
            if (r_clr_to_eof) begin
              r_clr_to_eof        <= 1'b0;
              Output_1_V_V        <= EOF_WORD;
              Output_1_V_V_ap_vld <= 1'b1;
              r_state             <= S_EOF_OUT;
            end else begin
              r_state <= S_ARB;
            end
          end
        end
        S_ARB: begin
          if (w_arb_found) begin
            r_lane   <= w_arb_lane;
            r_rr_ptr <= w_arb_lane;
            r_state  <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_cur_vld) begin
            if (w_cur_word == EOF_WORD) begin
              r_clr_to_eof <= 1'b1;
              r_state      <= S_CLEAR;
            end else if (w_cur_word[15:0] == 16'd0) begin
              r_state <= S_ARB;
            end else begin
              r_remaining <= w_cur_word[15:0];
              r_state     <= S_FRAG_RD;
            end
          end
        end
        S_FRAG_RD: begin
          if (w_cur_vld) begin
            r_fx        <= w_cur_word[31:24];
            r_fy        <= w_cur_word[23:16];
            r_fz        <= w_cur_word[15:8];
            r_fcol      <= w_cur_word[7:0];
            r_remaining <= r_remaining - 16'd1;
            r_state     <= S_FRAG_CMP;
          end
        end
        S_FRAG_CMP: begin
          if (w_pass) begin
            Output_1_V_V        <= {r_fx, r_fy, 8'h00, r_fcol};
            Output_1_V_V_ap_vld <= 1'b1;
            r_state             <= S_OUT_WAIT;
          end else begin
            r_state <= (r_remaining != 16'd0) ? S_FRAG_RD : S_ARB;
          end
        end
        S_OUT_WAIT: begin
          if (Output_1_V_V_ap_ack) begin
            Output_1_V_V_ap_vld <= 1'b0;
            r_state             <= (r_remaining != 16'd0) ? S_FRAG_RD : S_ARB;
          end
        end
        S_EOF_OUT: begin
          if (Output_1_V_V_ap_ack) begin
            Output_1_V_V_ap_vld <= 1'b0;
            r_state             <= S_ARB;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

`ifdef ZCULL_STATS_EN
  // Free-running statistics, cleared only by reset
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stat_frag_in   <= '0;
      stat_frag_pass <= '0;
      stat_frames    <= '0;
    end else begin
      if (r_state == S_FRAG_RD && w_cur_vld)
        stat_frag_in <= stat_frag_in + 32'd1;
      if (r_state == S_OUT_WAIT && Output_1_V_V_ap_ack)
        stat_frag_pass <= stat_frag_pass + 32'd1;
      if (r_state == S_EOF_OUT && Output_1_V_V_ap_ack)
        stat_frames <= stat_frames + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_zculling_stage.sv
// Scoreboard bench for zculling_stage. The Z-buffer is shrunk to 8 address
// bits (address = y) so every clear sweep is 256 cycles.
module tb_zculling_stage;

  localparam int unsigned ZB  = 8;
  localparam int unsigned CLR = 1 << ZB;
  localparam logic [31:0] EOFW = 32'hFFFF_FFFF;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [31:0] in_d [4];
  logic [3:0]  in_v = 4'b0;
  logic        a1, a2, a3, a4;
  logic [3:0]  in_a;
  logic [31:0] o_data;
  logic        o_vld;
  logic        oack = 1'b1;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];
  int          xfer_log [$];
  bit          log_en = 1'b0;

  assign in_a = {a4, a3, a2, a1};

  zculling_stage #(.ZB_ADDR_BITS(ZB)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .Input_1_V_V(in_d[0]), .Input_1_V_V_ap_vld(in_v[0]), .Input_1_V_V_ap_ack(a1),
    .Input_2_V_V(in_d[1]), .Input_2_V_V_ap_vld(in_v[1]), .Input_2_V_V_ap_ack(a2),
    .Input_3_V_V(in_d[2]), .Input_3_V_V_ap_vld(in_v[2]), .Input_3_V_V_ap_ack(a3),
    .Input_4_V_V(in_d[3]), .Input_4_V_V_ap_vld(in_v[3]), .Input_4_V_V_ap_ack(a4),
    .Output_1_V_V(o_data), .Output_1_V_V_ap_vld(o_vld), .Output_1_V_V_ap_ack(oack),
    .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur within bound", nm);
  endtask

  // Monitor: pop and compare each output transfer; log input transfers
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      if (o_vld && oack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got %h expected none", o_data);
        end else begin
          chk("out_word", o_data, exp_q.pop_front());
        end
      end
      if (|in_a) chk("ack_onehot", 32'($countones(in_a)), 32'd1);
      if (log_en)
        for (int i = 0; i < 4; i++)
          if (in_v[i] && in_a[i]) xfer_log.push_back(i + 1);
    end
  end

  // Present one word on a lane and hold it until acked; optionally expect an output
  task automatic send_word(input int unsigned ln, input logic [31:0] w,
                           input bit ex, input logic [31:0] exv);
    int unsigned t;
    in_d[ln] = w;
    in_v[ln] = 1'b1;
    t = 0;
    forever begin
      @(negedge ap_clk);
      if (in_a[ln]) break;
      t++;
      if (t > 3000) begin
        fail_now("lane_ack_wait");
        break;
      end
    end
    if (ex) exp_q.push_back(exv);
    @(posedge ap_clk);
    #1 in_v[ln] = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int unsigned t;
    t = 0;
    while (exp_q.size() != 0 || busy || o_vld) begin
      @(posedge ap_clk);
      #1 t++;
      if (t > 3000) begin
        fail_now(nm);
        break;
      end
    end
  endtask

  // Count posedges after reset release until busy drops; no ack may appear
  task automatic clear_after_reset(input string nm);
    int unsigned cnt;
    int unsigned acks;
    cnt  = 0;
    acks = 0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    forever begin
      @(posedge ap_clk);
      #1 cnt++;
      if (in_a != 4'b0) acks++;
      if (!busy || cnt > 4 * CLR) break;
    end
    chk({nm, "_busy_cycles"}, cnt, CLR);
    chk({nm, "_ack_in_clear"}, acks, 0);
  endtask

  initial begin
    int unsigned cnt;
    int exp_order [8];
    for (int i = 0; i < 4; i++) in_d[i] = '0;

    // Reset values
    #12;
    chk("rst_vld", o_vld, 1'b0);
    chk("rst_data", o_data, 32'h0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_ack", in_a, 4'b0);
    clear_after_reset("init");

    // Single lane: second fragment at same pixel is deeper and dropped
    send_word(0, 32'd2, 0, 0);
    send_word(0, 32'h0A0B_1005, 1, 32'h0A0B_0005);
    send_word(0, 32'h0A0B_2006, 0, 0);
    wait_idle("idle_t2");

    // Four simultaneous headers: served 2,3,4,1 with whole packets each
    log_en = 1'b1;
    fork
      begin send_word(0, 32'd1, 0, 0); send_word(0, 32'h1121_3011, 1, 32'h1121_0011); end
      begin send_word(1, 32'd1, 0, 0); send_word(1, 32'h1222_3012, 1, 32'h1222_0012); end
      begin send_word(2, 32'd1, 0, 0); send_word(2, 32'h1323_3013, 1, 32'h1323_0013); end
      begin send_word(3, 32'd1, 0, 0); send_word(3, 32'h1424_3014, 1, 32'h1424_0014); end
    join
    wait_idle("idle_t3");
    log_en = 1'b0;
    exp_order = '{2, 2, 3, 3, 4, 4, 1, 1};
    chk("rr_log_len", xfer_log.size(), 8);
    for (int i = 0; i < 8 && i < xfer_log.size(); i++)
      chk("rr_order", xfer_log[i], exp_order[i]);

    // Output stall: held data/vld, no input ack; zero-length packet afterwards
    oack = 1'b0;
    send_word(3, 32'd1, 0, 0);
    send_word(3, 32'h4430_5044, 1, 32'h4430_0044);
    cnt = 0;
    while (!o_vld && cnt < 10) begin @(negedge ap_clk); cnt++; end
    in_d[1] = 32'd0;
    in_v[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      chk("stall_vld", o_vld, 1'b1);
      chk("stall_data", o_data, 32'h4430_0044);
      chk("stall_no_ack", in_a, 4'b0);
    end
    @(posedge ap_clk);
    #1 oack = 1'b1;
    send_word(1, 32'd0, 0, 0);
    wait_idle("idle_t4");

    // EOF on lane 3: full clear, EOF marker, then depths start over
    send_word(2, EOFW, 1, EOFW);
    cnt = 0;
    forever begin
      @(posedge ap_clk);
      #1 cnt++;
      if (o_vld || cnt > 4 * CLR) break;
    end
    chk("eof_clear_cycles", cnt, CLR);
    wait_idle("idle_eof");
    send_word(0, 32'd1, 0, 0);
    send_word(0, 32'h0A0B_2006, 1, 32'h0A0B_0006);
    send_word(0, 32'd3, 0, 0);
    send_word(0, 32'h0A0B_2007, 0, 0);
    send_word(0, 32'h0A0B_1F08, 1, 32'h0A0B_0008);
    send_word(0, 32'h0A55_FF09, 0, 0);
    wait_idle("idle_t5");

    // Reset in FRAG_CMP with 5 fragments left
    send_word(0, 32'd6, 0, 0);
    send_word(0, 32'h0101_1001, 0, 0);
    in_d[0] = 32'h0101_1002;
    in_v[0] = 1'b1;
    ap_rst  = 1'b1;
    #1;
    chk("midrst_vld", o_vld, 1'b0);
    chk("midrst_data", o_data, 32'h0);
    chk("midrst_ack", in_a, 4'b0);
    chk("midrst_busy", busy, 1'b1);
    in_v[0] = 1'b0;
    clear_after_reset("midrst");
    chk("midrst_q_empty", exp_q.size(), 0);
    send_word(1, 32'd1, 0, 0);
    send_word(1, 32'h0202_1002, 1, 32'h0202_0002);
    wait_idle("idle_t6");
    repeat (5) @(posedge ap_clk);
    #1 chk("final_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    fail_now("global_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
